// File: rtl/hilo_reg_pkg.sv
// Shared definitions for the HI/LO register block: op encodings, default latencies and
// the latency-counter width.
package hilo_reg_pkg;

  typedef enum logic [1:0] {
    OP_MOVE = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_kind_e;

  localparam int unsigned DefMulLat = 4;
  localparam int unsigned DefDivLat = 33;
  localparam int unsigned CntW      = 6;

  // A latency of N commits on the Nth edge after accept, so the counter starts at N-1.
  function automatic logic [CntW-1:0] lat_load(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/hilo_reg_if.sv
// Bundle between mult/div control (master) and the HI/LO register block (slave).
interface hilo_reg_if;
  import hilo_reg_pkg::*;

  logic        op_valid;
  op_kind_e    op_kind;
  logic        wr_hi_we;
  logic        wr_lo_we;
  logic [31:0] wr_hi;
  logic [31:0] wr_lo;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport master (
    output op_valid, op_kind, wr_hi_we, wr_lo_we, wr_hi, wr_lo, rd_req, rd_sel,
    input  rd_data, stall, hi_q, lo_q
  );

  modport slave (
    input  op_valid, op_kind, wr_hi_we, wr_lo_we, wr_hi, wr_lo, rd_req, rd_sel,
    output rd_data, stall, hi_q, lo_q
  );

endinterface

// File: rtl/hilo_reg_lat_counter.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module hilo_reg_lat_counter
  import hilo_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_reg.sv
// MIPS-style HI/LO register pair with delayed multiply/divide commit, pipeline stall
// and a same-cycle read bypass of the committing result.
module hilo_reg
  import hilo_reg_pkg::*;
#(
  parameter int unsigned MUL_LAT = DefMulLat,
  parameter int unsigned DIV_LAT = DefDivLat
) (
  input logic       clk,
  input logic       rstn,
  hilo_reg_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_hi_we_q, pend_hi_we_d, pend_lo_we_q, pend_lo_we_d;
  logic        busy, cnt_zero, commit, accept, move;
  logic [CntW-1:0] load_val;
  logic [31:0] rd_data;

  assign busy     = (state_q == StBusy);
  assign commit   = busy & cnt_zero;
  assign move     = !busy & bus.op_valid & (bus.op_kind == OP_MOVE);
  assign accept   = !busy & bus.op_valid & ((bus.op_kind == OP_MUL) || (bus.op_kind == OP_DIV));
  assign load_val = (bus.op_kind == OP_MUL) ? lat_load(MUL_LAT) : lat_load(DIV_LAT);

  hilo_reg_lat_counter u_lat_counter (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (accept),
    .load_val_i (load_val),
    .dec_i      (busy),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_hi_we_d = pend_hi_we_q;
    pend_lo_we_d = pend_lo_we_q;
    if (move) begin
      if (bus.wr_hi_we) hi_d = bus.wr_hi;
      if (bus.wr_lo_we) lo_d = bus.wr_lo;
    end
    if (accept) begin
      pend_hi_d    = bus.wr_hi;
      pend_lo_d    = bus.wr_lo;
      pend_hi_we_d = bus.wr_hi_we;
      pend_lo_we_d = bus.wr_lo_we;
      state_d      = StBusy;
    end
    if (commit) begin
      if (pend_hi_we_q) hi_d = pend_hi_q;
      if (pend_lo_we_q) lo_d = pend_lo_q;
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_hi_we_q <= 1'b0;
      pend_lo_we_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_hi_we_q <= pend_hi_we_d;
      pend_lo_we_q <= pend_lo_we_d;
    end
  end

  // In the commit cycle the result is forwarded so a waiting mfhi/mflo can retire now.
  always_comb begin
    if (bus.rd_sel) begin
      rd_data = (commit && pend_hi_we_q) ? pend_hi_q : hi_q;
    end else begin
      rd_data = (commit && pend_lo_we_q) ? pend_lo_q : lo_q;
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.stall   = busy & (bus.op_valid | (bus.rd_req & !cnt_zero));
  assign bus.hi_q    = hi_q;
  assign bus.lo_q    = lo_q;

endmodule

// File: tb/tb_hilo_reg.sv
// Bench for hilo_reg: directed scenarios plus a randomized run against a cycle-count model.
module tb_hilo_reg;
  import hilo_reg_pkg::*;

  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 33;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  hilo_reg_if bus ();

  hilo_reg #(
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.op_kind  = OP_MOVE;
    bus.wr_hi_we = 1'b0;
    bus.wr_lo_we = 1'b0;
    bus.wr_hi    = '0;
    bus.wr_lo    = '0;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    bus.op_valid = 1'b1;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b1;
    bus.wr_hi    = 32'hDEAD_0001;
    bus.wr_lo    = 32'hDEAD_0002;
    cyc();
    cyc();
    rstn = 1'b1;
    idle_inputs();
    #1;
    tests++; if (bus.hi_q !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected %h", bus.hi_q, 32'h0); end
    tests++; if (bus.lo_q !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected %h", bus.lo_q, 32'h0); end
    tests++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd: got %h expected %h", bus.rd_data, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
  endtask

  task automatic test_move();
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_MOVE;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b0;
    bus.wr_hi    = 32'h1234_5678;
    bus.wr_lo    = 32'hDEAD_BEEF;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL move_stall: got %b expected 0", bus.stall); end
    cyc();
    idle_inputs();
    #1;
    tests++; if (bus.hi_q !== 32'h1234_5678) begin fails++; $display("FAIL move_hi: got %h expected %h", bus.hi_q, 32'h1234_5678); end
    tests++; if (bus.lo_q !== 32'h0) begin fails++; $display("FAIL move_lo: got %h expected %h", bus.lo_q, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL move_stall2: got %b expected 0", bus.stall); end
  endtask

  task automatic test_mul_bypass();
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_MUL;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b1;
    bus.wr_hi    = 32'hFFFF_FFFF;
    bus.wr_lo    = 32'h0000_0001;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mul_accept_stall: got %b expected 0", bus.stall); end
    cyc();
    idle_inputs();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL mul_stall[%0d]: got %b expected 1", i, bus.stall); end
      cyc();
    end
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mul_commit_stall: got %b expected 0", bus.stall); end
    tests++; if (bus.rd_data !== 32'h1) begin fails++; $display("FAIL mul_bypass: got %h expected %h", bus.rd_data, 32'h1); end
    tests++; if (bus.lo_q !== 32'h0) begin fails++; $display("FAIL mul_lo_pre: got %h expected %h", bus.lo_q, 32'h0); end
    cyc();
    tests++; if (bus.lo_q !== 32'h1) begin fails++; $display("FAIL mul_lo: got %h expected %h", bus.lo_q, 32'h1); end
    tests++; if (bus.hi_q !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mul_hi: got %h expected %h", bus.hi_q, 32'hFFFF_FFFF); end
    idle_inputs();
  endtask

  task automatic test_div_back_to_back();
    int n;
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_DIV;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b1;
    bus.wr_hi    = 32'h0000_0011;
    bus.wr_lo    = 32'h0000_0022;
    cyc();
    bus.op_kind = OP_MUL;
    bus.wr_hi   = 32'h0000_0033;
    bus.wr_lo   = 32'h0000_0044;
    n = 0;
    #1;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    tests++; if (n !== 33) begin fails++; $display("FAIL div_stall_cycles: got %0d expected %0d", n, 33); end
    tests++; if (bus.hi_q !== 32'h11) begin fails++; $display("FAIL div_hi: got %h expected %h", bus.hi_q, 32'h11); end
    tests++; if (bus.lo_q !== 32'h22) begin fails++; $display("FAIL div_lo: got %h expected %h", bus.lo_q, 32'h22); end
    cyc();
    idle_inputs();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1;
    tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL second_accept_stall: got %b expected 1", bus.stall); end
    cyc();
    cyc();
    cyc();
    tests++; if (bus.rd_data !== 32'h33) begin fails++; $display("FAIL second_bypass: got %h expected %h", bus.rd_data, 32'h33); end
    cyc();
    tests++; if (bus.hi_q !== 32'h33) begin fails++; $display("FAIL second_hi: got %h expected %h", bus.hi_q, 32'h33); end
    tests++; if (bus.lo_q !== 32'h44) begin fails++; $display("FAIL second_lo: got %h expected %h", bus.lo_q, 32'h44); end
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_DIV;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b1;
    bus.wr_hi    = 32'h5555_5555;
    bus.wr_lo    = 32'h6666_6666;
    cyc();
    idle_inputs();
    for (int i = 0; i < 9; i++) cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    tests++; if (bus.hi_q !== 32'h0) begin fails++; $display("FAIL rbusy_hi: got %h expected %h", bus.hi_q, 32'h0); end
    tests++; if (bus.lo_q !== 32'h0) begin fails++; $display("FAIL rbusy_lo: got %h expected %h", bus.lo_q, 32'h0); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rbusy_stall: got %b expected 0", bus.stall); end
    for (int i = 0; i < 40; i++) cyc();
    tests++; if (bus.hi_q !== 32'h0) begin fails++; $display("FAIL rbusy_hi_late: got %h expected %h", bus.hi_q, 32'h0); end
    tests++; if (bus.lo_q !== 32'h0) begin fails++; $display("FAIL rbusy_lo_late: got %h expected %h", bus.lo_q, 32'h0); end
    idle_inputs();
  endtask

  task automatic test_move_read();
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_MOVE;
    bus.wr_lo_we = 1'b1;
    bus.wr_lo    = 32'h1;
    cyc();
    bus.wr_lo  = 32'hA5A5_A5A5;
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0;
    #1;
    tests++; if (bus.rd_data !== 32'h1) begin fails++; $display("FAIL move_read_same: got %h expected %h", bus.rd_data, 32'h1); end
    cyc();
    bus.op_valid = 1'b0;
    #1;
    tests++; if (bus.rd_data !== 32'hA5A5_A5A5) begin fails++; $display("FAIL move_read_next: got %h expected %h", bus.rd_data, 32'hA5A5_A5A5); end
    idle_inputs();
  endtask

  task automatic test_reserved();
    bus.op_valid = 1'b1;
    bus.op_kind  = OP_RSVD;
    bus.wr_hi_we = 1'b1;
    bus.wr_lo_we = 1'b1;
    bus.wr_hi    = $urandom;
    bus.wr_lo    = $urandom;
    #1;
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rsvd_stall: got %b expected 0", bus.stall); end
    cyc();
    idle_inputs();
    bus.rd_req = 1'b1;
    #1;
    tests++; if (bus.hi_q !== 32'h0) begin fails++; $display("FAIL rsvd_hi: got %h expected %h", bus.hi_q, 32'h0); end
    tests++; if (bus.lo_q !== 32'hA5A5_A5A5) begin fails++; $display("FAIL rsvd_lo: got %h expected %h", bus.lo_q, 32'hA5A5_A5A5); end
    tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rsvd_not_busy: got %b expected 0", bus.stall); end
    idle_inputs();
  endtask

  // Model: an accepted op commits on the edge exactly LAT edges after its accept edge.
  task automatic test_random();
    int          edges, commit_edge;
    bit          m_busy, commit_now, hold, exp_stall;
    logic [31:0] m_hi, m_lo, p_hi, p_lo, exp_rd;
    bit          p_hwe, p_lwe;
    rstn = 1'b0;
    idle_inputs();
    cyc();
    rstn = 1'b1;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_hwe = 0; p_lwe = 0;
    m_busy = 0; commit_edge = 0; edges = 0; hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        bus.op_valid = ($urandom_range(0, 3) == 0);
        bus.op_kind  = op_kind_e'($urandom_range(0, 3));
        bus.wr_hi_we = 1'($urandom_range(0, 1));
        bus.wr_lo_we = 1'($urandom_range(0, 1));
        bus.wr_hi    = $urandom;
        bus.wr_lo    = $urandom;
        bus.rd_req   = 1'($urandom_range(0, 1));
        bus.rd_sel   = 1'($urandom_range(0, 1));
      end
      rstn = ($urandom_range(0, 149) != 0);
      #1;
      commit_now = m_busy && (edges + 1 == commit_edge);
      exp_stall  = m_busy && (bus.op_valid || (bus.rd_req && !commit_now));
      if (bus.rd_sel) exp_rd = (commit_now && p_hwe) ? p_hi : m_hi;
      else            exp_rd = (commit_now && p_lwe) ? p_lo : m_lo;
      tests++; if (bus.stall !== exp_stall) begin fails++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, bus.stall, exp_stall); end
      tests++; if (bus.rd_data !== exp_rd) begin fails++; $display("FAIL rand_rd[%0d]: got %h expected %h", i, bus.rd_data, exp_rd); end
      hold = exp_stall;
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_hwe = 0; p_lwe = 0; m_busy = 0;
      end else if (m_busy) begin
        if (commit_now) begin
          if (p_hwe) m_hi = p_hi;
          if (p_lwe) m_lo = p_lo;
          m_busy = 0;
        end
      end else if (bus.op_valid) begin
        if (bus.op_kind == OP_MOVE) begin
          if (bus.wr_hi_we) m_hi = bus.wr_hi;
          if (bus.wr_lo_we) m_lo = bus.wr_lo;
        end else if (bus.op_kind != OP_RSVD) begin
          m_busy = 1;
          commit_edge = edges + 1 + ((bus.op_kind == OP_MUL) ? int'(MulLat) : int'(DivLat));
          p_hi = bus.wr_hi; p_lo = bus.wr_lo; p_hwe = bus.wr_hi_we; p_lwe = bus.wr_lo_we;
        end
      end
      edges++;
      tests++; if (bus.hi_q !== m_hi) begin fails++; $display("FAIL rand_hi[%0d]: got %h expected %h", i, bus.hi_q, m_hi); end
      tests++; if (bus.lo_q !== m_lo) begin fails++; $display("FAIL rand_lo[%0d]: got %h expected %h", i, bus.lo_q, m_lo); end
    end
    rstn = 1'b1;
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    idle_inputs();
    test_reset();
    test_move();
    test_mul_bypass();
    test_div_back_to_back();
    test_reset_busy();
    test_move_read();
    test_reserved();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
